// File: rtl/ps2_key_fifo.sv
// ps2_key_fifo: keystroke FIFO between the PS/2 decoder and the CPU bus.
// Ports: clk, rst (async high); ascii_code/key_pressed push side;
// bus_sel/bus_addr/bus_rd/bus_wr/bus_wdata -> bus_rdata (registered);
// irq is high while the FIFO holds data.
module ps2_key_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ascii_code,
  input  logic        key_pressed,
  input  logic        bus_sel,
  input  logic        bus_addr,
  input  logic        bus_rd,
  input  logic        bus_wr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        irq
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          ovf;

  logic          not_empty;
  logic          full;
  logic          rd_data;
  logic          rd_stat;
  logic          pop;
  logic          push;
  logic          ovf_set;
  logic          ovf_clr;
  logic [7:0]    cnt8;
  logic [31:0]   status;
  logic          unused_wdata;

  assign not_empty = (count != '0);
  assign full      = (count == CNT_FULL);
  assign rd_data   = bus_sel & bus_rd & ~bus_addr;
  assign rd_stat   = bus_sel & bus_rd & bus_addr;
  assign pop       = rd_data & not_empty;
  // A pop in the same edge frees a slot, so a full FIFO still accepts.
  assign push      = key_pressed & (~full | pop);
  assign ovf_set   = key_pressed & full & ~pop;
  assign ovf_clr   = bus_sel & bus_wr & bus_addr & bus_wdata[1];
  assign cnt8      = 8'(count);
  assign status    = {16'h0, cnt8, 6'b0, ovf, not_empty};
  assign irq       = not_empty;

  assign unused_wdata = ^{bus_wdata[31:2], bus_wdata[0]};

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= ascii_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
    end
  end

  // Set has priority over a clear arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  // Read data holds between reads; status captures pre-edge ovf.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_rdata <= '0;
    end else if (rd_data) begin
      bus_rdata <= not_empty ? {24'h0, mem[rd_ptr]} : 32'h0;
    end else if (rd_stat) begin
      bus_rdata <= status;
    end
  end

endmodule

// File: tb/tb_ps2_key_fifo.sv
// tb_ps2_key_fifo: scoreboard bench for ps2_key_fifo.
// Queue model of FIFO contents plus overflow flag.
module tb_ps2_key_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  ascii_code = '0;
  logic        key_pressed = 1'b0;
  logic        bus_sel = 1'b0;
  logic        bus_addr = 1'b0;
  logic        bus_rd = 1'b0;
  logic        bus_wr = 1'b0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        irq;

  int checks = 0;
  int failures = 0;
  logic [7:0] q[$];
  logic ovf_m = 1'b0;

  ps2_key_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk(clk),
    .rst(rst),
    .ascii_code(ascii_code),
    .key_pressed(key_pressed),
    .bus_sel(bus_sel),
    .bus_addr(bus_addr),
    .bus_rd(bus_rd),
    .bus_wr(bus_wr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp();
    logic ne;
    ne = (q.size() != 0);
    return {16'h0, 8'(q.size()), 6'b0, ovf_m, ne};
  endfunction

  task automatic step(input logic kp, input logic [7:0] code,
                      input logic rd, input logic wr,
                      input logic addr, input logic [31:0] wd);
    key_pressed = kp;
    ascii_code  = code;
    bus_sel     = rd | wr;
    bus_rd      = rd;
    bus_wr      = wr;
    bus_addr    = addr;
    bus_wdata   = wd;
    @(negedge clk);
    key_pressed = 1'b0;
    ascii_code  = '0;
    bus_sel     = 1'b0;
    bus_rd      = 1'b0;
    bus_wr      = 1'b0;
    bus_addr    = 1'b0;
    bus_wdata   = '0;
    check("irq", {31'b0, irq}, {31'b0, q.size() != 0});
  endtask

  task automatic push(input logic [7:0] b);
    if (q.size() < DEPTH) q.push_back(b);
    else ovf_m = 1'b1;
    step(1'b1, b, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic rd_data(input string tag);
    logic [31:0] exp;
    exp = (q.size() != 0) ? {24'h0, q.pop_front()} : 32'h0;
    step(1'b0, 8'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    check(tag, bus_rdata, exp);
  endtask

  task automatic rd_status(input string tag);
    logic [31:0] exp;
    exp = stat_exp();
    step(1'b0, 8'h0, 1'b1, 1'b0, 1'b1, 32'h0);
    check(tag, bus_rdata, exp);
  endtask

  task automatic push_read(input string tag, input logic [7:0] b);
    logic [31:0] exp;
    exp = (q.size() != 0) ? {24'h0, q.pop_front()} : 32'h0;
    q.push_back(b);
    step(1'b1, b, 1'b1, 1'b0, 1'b0, 32'h0);
    check(tag, bus_rdata, exp);
  endtask

  task automatic clr_ovf();
    ovf_m = 1'b0;
    step(1'b0, 8'h0, 1'b0, 1'b1, 1'b1, 32'h2);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    check("rst_rdata", bus_rdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd_status("rst_status");
    check("rst_status_lit", bus_rdata, 32'h0);

    push(8'h31);
    rd_status("single_status");
    check("single_status_lit", bus_rdata, 32'h0000_0101);
    rd_data("single_data");
    check("single_data_lit", bus_rdata, 32'h31);
    rd_status("single_status2");

    for (int i = 0; i < 16; i++) push(8'(8'h41 + i));
    rd_status("order_full_status");
    for (int i = 0; i < 16; i++) rd_data("order_data");
    for (int i = 0; i < 3; i++) push(8'(8'h61 + i));
    for (int i = 0; i < 3; i++) rd_data("wrap_data");
    rd_status("wrap_status");

    for (int i = 0; i < 17; i++) push(8'(8'h80 + i));
    rd_status("ovf_status");
    check("ovf_status_lit", bus_rdata, 32'h0000_1003);
    clr_ovf();
    rd_status("ovf_clr_status");
    check("ovf_clr_lit", bus_rdata, 32'h0000_1001);

    ovf_m = 1'b1;
    step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1, 32'h2);
    rd_status("set_beats_clr");

    begin
      logic [31:0] exp;
      exp = stat_exp();
      ovf_m = 1'b0;
      step(1'b0, 8'h0, 1'b1, 1'b1, 1'b1, 32'h2);
      check("rdwr_status", bus_rdata, exp);
    end
    rd_status("rdwr_after");

    push_read("full_pushpop", 8'h7A);
    rd_status("full_pushpop_status");
    for (int i = 0; i < 16; i++) rd_data("drain_data");
    check("last_is_7a", bus_rdata, 32'h7A);

    push_read("empty_pushpop", 8'h7B);
    rd_status("empty_pushpop_status");
    rd_data("empty_pushpop_data");

    rd_data("empty_read");
    rd_status("empty_read_status");

    push(8'h11);
    push(8'h12);
    #2 rst = 1'b1;
    #1;
    q.delete();
    ovf_m = 1'b0;
    check("midrst_irq", {31'b0, irq}, 32'h0);
    check("midrst_rdata", bus_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd_status("midrst_status");
    rd_data("midrst_data");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
